fpga_oddr_serializer: RTL and testbench

//  Sequences the technology ODDR primitive (fpga_oddr): accepts DW-bit parallel words over a

---
 rtl/fpga_oddr_serializer_if.sv | 12 +
 rtl/fpga_oddr_serializer.sv | 93 +++++++++
 tb/tb_fpga_oddr_serializer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/fpga_oddr_serializer_if.sv
// Parallel-word handshake between the peripheral datapath (master)
// and the ODDR serializer (slave).
interface fpga_oddr_serializer_if #(
   parameter int DW = 16
);
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/fpga_oddr_serializer.sv
// Feeds the fpga_oddr primitive two bits per clock (d[0] rising, d[1] falling)
// from DW-bit words. Bit 0 of each word goes out first. Back-to-back words are
// gapless. A starved stream raises a sticky underrun flag.
module fpga_oddr_serializer #(
   parameter int   DW       = 16,
   parameter logic IDLE_LVL = 1'b0,
   parameter int   CW       = 16
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  en,
   fpga_oddr_serializer_if.slave src,
   output logic [1:0]            oddr_d,
   output logic                  busy,
   output logic                  underrun,
   input  logic                  underrun_clr,
   output logic [CW-1:0]         word_cnt
);

   localparam int NB = DW / 2;
   localparam int BW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_SHIFT = 1'b1;

   logic [0:0]    state;
   logic [DW-1:0] shreg;
   logic [BW-1:0] beat;
   logic          last_beat;
   logic          take;
   logic          starve;

   // The ready window opens in IDLE, or on the final beat so the next word
   // follows the last pair with no idle beat; held low during reset.
   always_comb begin
      last_beat    = (state == S_SHIFT) && (beat == LAST_BEAT);
      src.in_ready = arst_n && en && ((state == S_IDLE) || last_beat);
      take         = src.in_ready && src.in_valid;
      starve       = last_beat && en && !src.in_valid;
   end

   assign busy = (state == S_SHIFT);

   // Word sequencer: load on handshake, shift one pair per clock, count completed words.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state    <= S_IDLE;
         shreg    <= '0;
         beat     <= '0;
         oddr_d   <= {IDLE_LVL, IDLE_LVL};
         word_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               oddr_d <= {IDLE_LVL, IDLE_LVL};
               if (take) begin
                  shreg <= src.in_data;
                  beat  <= '0;
                  state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               oddr_d <= shreg[1:0];
               shreg  <= shreg >> 2;
               beat   <= beat + 1'b1;
               if (last_beat) begin
                  word_cnt <= word_cnt + 1'b1;
                  if (take) begin
                     shreg <= src.in_data;
                     beat  <= '0;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Sticky underrun: a starvation on the final beat outranks a same-cycle clear.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         underrun <= 1'b0;
      end else if (starve) begin
         underrun <= 1'b1;
      end else if (underrun_clr) begin
         underrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fpga_oddr_serializer.sv
// Scoreboard bench for fpga_oddr_serializer (DW=16, CW=4): the driver queues
// the expected bit pairs of every accepted word, an independent monitor checks
// oddr_d each cycle against that queue or the idle level.
module tb_fpga_oddr_serializer;

   logic       clk = 1'b0;
   logic       arst_n = 1'b1;
   logic       en = 1'b0;
   logic       underrun_clr = 1'b0;
   logic [1:0] oddr_d;
   logic       busy;
   logic       underrun;
   logic [3:0] word_cnt;

   int n_chk  = 0;
   int n_pass = 0;

   logic [1:0] exp_q[$];
   logic       prev_busy = 1'b0;

   fpga_oddr_serializer_if #(.DW(16)) bus ();

   fpga_oddr_serializer #(.DW(16), .IDLE_LVL(1'b0), .CW(4)) dut (
      .clk          (clk),
      .arst_n       (arst_n),
      .en           (en),
      .src          (bus),
      .oddr_d       (oddr_d),
      .busy         (busy),
      .underrun     (underrun),
      .underrun_clr (underrun_clr),
      .word_cnt     (word_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Offer one word, wait (bounded) for in_ready, queue its 8 pairs, complete the handshake.
   task automatic push_word(input logic [15:0] w, output int waited);
      int t = 0;
      bus.in_data  = w;
      bus.in_valid = 1'b1;
      #1;
      while (!bus.in_ready && t < 100) begin
         @(negedge clk);
         #1;
         t++;
      end
      waited = t;
      if (!bus.in_ready) begin
         n_chk++;
         $display("FAIL handshake_timeout: in_ready got 0 expected 1 at %0t", $time);
         bus.in_valid = 1'b0;
      end else begin
         for (int i = 0; i < 8; i++) exp_q.push_back(w[2*i +: 2]);
         @(posedge clk);
         #1;
      end
   endtask

   // A data pair appears on oddr_d one clock after the state was SHIFT; otherwise the idle level.
   always @(negedge clk) begin
      if (!arst_n) begin
         prev_busy = 1'b0;
      end else begin
         if (prev_busy) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL beat_extra: got %0b expected idle/no beat at %0t", oddr_d, $time);
            end else begin
               check("beat", {30'd0, oddr_d}, {30'd0, exp_q.pop_front()});
            end
         end else begin
            check("idle", {30'd0, oddr_d}, 32'd0);
         end
         prev_busy = busy;
      end
   end

   logic [15:0] t6_words [17] = '{16'h0001, 16'h8000, 16'hAAAA, 16'h5555, 16'h00FF, 16'hFF00,
                                  16'h1357, 16'h2468, 16'hDEAD, 16'hC0DE, 16'h0F0F, 16'hF0F0,
                                  16'h7E81, 16'h4321, 16'h9999, 16'h6006, 16'hFACE};
   int          t6_gaps  [17] = '{0, 2, 0, 0, 1, 0, 3, 0, 0, 1, 0, 0, 0, 2, 0, 1, 1};

   initial begin
      int wt;
      int prev_gap;
      bus.in_data  = '0;
      bus.in_valid = 1'b0;

      // Power-up reset, with en high to show in_ready stays low in reset
      en = 1'b1;
      #1 arst_n = 1'b0;
      #1;
      check("rst_oddr_d",   {30'd0, oddr_d}, 32'd0);
      check("rst_busy",     {31'd0, busy}, 32'd0);
      check("rst_underrun", {31'd0, underrun}, 32'd0);
      check("rst_word_cnt", {28'd0, word_cnt}, 32'd0);
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      @(posedge clk);
      #3 arst_n = 1'b1;
      @(negedge clk);

      // Single word, en held: starves after the last beat
      push_word(16'hA5C3, wt);
      bus.in_valid = 1'b0;
      repeat (10) @(negedge clk);
      check("t2_word_cnt", {28'd0, word_cnt}, 32'd1);
      check("t2_underrun", {31'd0, underrun}, 32'd1);
      check("t2_busy",     {31'd0, busy}, 32'd0);
      underrun_clr = 1'b1;
      @(negedge clk);
      underrun_clr = 1'b0;
      check("t2_underrun_clr", {31'd0, underrun}, 32'd0);

      // Back-to-back three words; en dropped during the last so the stream ends cleanly
      push_word(16'h1E2D, wt);
      check("t3_wait_w1", wt, 32'd0);
      push_word(16'hF00F, wt);
      check("t3_wait_w2", wt, 32'd8);
      push_word(16'h8001, wt);
      check("t3_wait_w3", wt, 32'd8);
      bus.in_valid = 1'b0;
      en = 1'b0;
      repeat (10) @(negedge clk);
      check("t3_word_cnt", {28'd0, word_cnt}, 32'd4);
      check("t3_underrun", {31'd0, underrun}, 32'd0);
      check("t3_in_ready", {31'd0, bus.in_ready}, 32'd0);

      // en dropped on beat 3: word still completes, no underrun, no new handshakes
      en = 1'b1;
      push_word(16'h6A95, wt);
      bus.in_valid = 1'b0;
      repeat (4) @(negedge clk);
      en = 1'b0;
      #1 check("t4_ready_midword", {31'd0, bus.in_ready}, 32'd0);
      repeat (6) @(negedge clk);
      check("t4_busy",     {31'd0, busy}, 32'd0);
      check("t4_underrun", {31'd0, underrun}, 32'd0);
      check("t4_word_cnt", {28'd0, word_cnt}, 32'd5);
      bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1 check("t4_ready_en0", {31'd0, bus.in_ready}, 32'd0);
      end
      bus.in_valid = 1'b0;
      check("t4_word_cnt_hold", {28'd0, word_cnt}, 32'd5);

      // Clear racing a new starvation: set wins, next clear takes effect
      en = 1'b1;
      @(negedge clk);
      check("t5_underrun_pre", {31'd0, underrun}, 32'd0);
      push_word(16'h3C5A, wt);
      bus.in_valid = 1'b0;
      repeat (8) @(negedge clk);
      underrun_clr = 1'b1;
      @(negedge clk);
      underrun_clr = 1'b0;
      check("t5_set_wins", {31'd0, underrun}, 32'd1);
      underrun_clr = 1'b1;
      @(negedge clk);
      underrun_clr = 1'b0;
      check("t5_cleared",  {31'd0, underrun}, 32'd0);
      check("t5_word_cnt", {28'd0, word_cnt}, 32'd6);

      // Asynchronous reset mid-SHIFT, away from any clock edge
      push_word(16'hBEEF, wt);
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3 arst_n = 1'b0;
      #1;
      check("t1_oddr_d",   {30'd0, oddr_d}, 32'd0);
      check("t1_busy",     {31'd0, busy}, 32'd0);
      check("t1_word_cnt", {28'd0, word_cnt}, 32'd0);
      check("t1_in_ready", {31'd0, bus.in_ready}, 32'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #3 arst_n = 1'b1;

      // 17 words with valid gaps; 4-bit counter wraps to 1
      prev_gap = 1;
      for (int i = 0; i < 17; i++) begin
         push_word(t6_words[i], wt);
         check("t6_ready_wait", wt, (prev_gap > 0) ? 32'd0 : 32'd8);
         if (t6_gaps[i] > 0) begin
            bus.in_valid = 1'b0;
            check("t6_no_early_underrun", {31'd0, underrun}, 32'd0);
            repeat (9) @(negedge clk);
            check("t6_gap_underrun", {31'd0, underrun}, 32'd1);
            underrun_clr = 1'b1;
            @(negedge clk);
            underrun_clr = 1'b0;
            check("t6_gap_cleared", {31'd0, underrun}, 32'd0);
            repeat (t6_gaps[i]) @(negedge clk);
         end
         prev_gap = t6_gaps[i];
      end
      repeat (2) @(negedge clk);
      check("t6_word_cnt", {28'd0, word_cnt}, 32'd1);
      check("t6_busy",     {31'd0, busy}, 32'd0);
      check("exp_q_drained", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
